fetch_queue: RTL

Small instruction prefetch queue between the PC register and instruction memory on one side and the ID stage on the other. Each cycle it captures the fetched {PC, instruction} pair and presents the oldest held pair to decode. It drives the PC register's write enable so that fetch stalls only when the queue is full. It absorbs load-use stalls from the hazard unit and discards wrong-path instructions on a branch flush.

---
 rtl/fetch_queue.sv | 88 ++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: prefetch FIFO between fetch (PC + imem) and the ID stage.
// Stalls the PC only when full; flush drops every queued instruction.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              fetch_pc,
  input  logic [31:0]              fetch_instr,
  input  logic                     fetch_valid,
  output logic                     pc_write,
  input  logic                     id_stall,
  input  logic                     flush,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_instr,
  output logic                     id_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full;
  logic          enq;
  logic          deq;

  assign full     = (cnt_q == CW'(DEPTH));
  assign pc_write = flush | ~full | ~id_stall;
  assign id_valid = (cnt_q != '0);
  assign deq      = id_valid & ~id_stall & ~flush;
  assign enq      = fetch_valid & pc_write & ~flush;

  assign id_pc    = id_valid ? mem_q[rptr_q].pc    : 32'h0;
  assign id_instr = id_valid ? mem_q[rptr_q].instr : 32'h0;
  assign count    = cnt_q;

  // Next pointer/occupancy; flush rewinds everything to empty.
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (deq) rptr_d = rptr_q + AW'(1);
      if (enq) wptr_d = wptr_q + AW'(1);
      unique case ({enq, deq})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage; a full slot is only rewritten once its deq frees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (enq) begin
      mem_q[wptr_q] <= '{pc: fetch_pc, instr: fetch_instr};
    end
  end

endmodule
